// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register file write port arbiter (ALU writeback vs long-latency unit)

`ifndef REG_IDX_W
`define REG_IDX_W 5
`endif
`ifndef WORD_W
`define WORD_W 32
`endif

module wb_port_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  i_alu_en,
  input  logic [`REG_IDX_W-1:0] i_alu_reg,
  input  logic [`WORD_W-1:0]    i_alu_data,
  input  logic                  i_ll_valid,
  input  logic [`REG_IDX_W-1:0] i_ll_reg,
  input  logic [`WORD_W-1:0]    i_ll_data,
  output logic                  o_ll_ready,
  output logic                  o_stall,
  output logic                  o_rf_we,
  output logic [`REG_IDX_W-1:0] o_rf_reg,
  output logic [`WORD_W-1:0]    o_rf_data,
  output logic [CNT_W-1:0]      o_stall_cnt
);

  typedef enum logic {ARB, STALL} state_t;

  // Last tolerated blocked count before a forced bubble
  localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

  state_t                  r_state;
  logic [3:0]              r_wait_cnt;
  logic                    r_stall;
  logic                    r_rf_we;
  logic [`REG_IDX_W-1:0]   r_rf_reg;
  logic [`WORD_W-1:0]      r_rf_data;
  logic [CNT_W-1:0]        r_stall_cnt;

  logic w_alu_act;
  logic w_ll_x0;
  logic w_ll_ready;
  logic w_ll_hs;
  logic w_ll_blocked;

  // Writes to x0 never occupy the port; LL x0 writes are swallowed at once
  assign w_alu_act    = i_alu_en && (i_alu_reg != '0);
  assign w_ll_x0      = i_ll_valid && (i_ll_reg == '0);
  assign w_ll_ready   = clr && i_ll_valid && (w_ll_x0 || !w_alu_act);
  assign w_ll_hs      = w_ll_ready;
  assign w_ll_blocked = i_ll_valid && !w_ll_ready;

  assign o_ll_ready  = w_ll_ready;
  assign o_stall     = r_stall;
  assign o_rf_we     = r_rf_we;
  assign o_rf_reg    = r_rf_reg;
  assign o_rf_data   = r_rf_data;
  assign o_stall_cnt = r_stall_cnt;

  // Registered write port: ALU first, then an accepted non-x0 LL write
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_rf_we   <= 1'b0;
      r_rf_reg  <= '0;
      r_rf_data <= '0;
    end else if (w_alu_act) begin
      r_rf_we   <= 1'b1;
      r_rf_reg  <= i_alu_reg;
      r_rf_data <= i_alu_data;
    end else if (w_ll_hs && !w_ll_x0) begin
      r_rf_we   <= 1'b1;
      r_rf_reg  <= i_ll_reg;
      r_rf_data <= i_ll_data;
    end else begin
      r_rf_we   <= 1'b0;
    end
  end

  // Bounded-wait scheduler: count blocked LL cycles, force a bubble at the limit
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state     <= ARB;
      r_wait_cnt  <= '0;
      r_stall     <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      case (r_state)
        ARB: begin
          if (w_ll_blocked) begin
            if (r_wait_cnt == WAIT_LAST) begin
              r_state    <= STALL;
              r_stall    <= 1'b1;
              r_wait_cnt <= '0;
              if (r_stall_cnt != '1) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
              end
            end else begin
              r_wait_cnt <= r_wait_cnt + 4'd1;
            end
          end else begin
            r_wait_cnt <= '0;
          end
        end
        STALL: begin
          // An in-flight ALU write may still win the first STALL cycle
          if (w_ll_hs || !i_ll_valid) begin
            r_state    <= ARB;
            r_stall    <= 1'b0;
            r_wait_cnt <= '0;
          end
        end
        default: begin
          r_state    <= ARB;
          r_stall    <= 1'b0;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - scoreboard testbench for wb_port_arbiter

`ifndef REG_IDX_W
`define REG_IDX_W 5
`endif
`ifndef WORD_W
`define WORD_W 32
`endif

module tb_wb_port_arbiter;

  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 4;

  typedef struct {
    logic [`REG_IDX_W-1:0] r;
    logic [`WORD_W-1:0]    d;
  } wr_t;

  logic                  clk = 1'b0;
  logic                  clr;
  logic                  i_alu_en;
  logic [`REG_IDX_W-1:0] i_alu_reg;
  logic [`WORD_W-1:0]    i_alu_data;
  logic                  i_ll_valid;
  logic [`REG_IDX_W-1:0] i_ll_reg;
  logic [`WORD_W-1:0]    i_ll_data;
  logic                  o_ll_ready;
  logic                  o_stall;
  logic                  o_rf_we;
  logic [`REG_IDX_W-1:0] o_rf_reg;
  logic [`WORD_W-1:0]    o_rf_data;
  logic [CNT_W-1:0]      o_stall_cnt;

  int n_checks = 0;
  int n_fails  = 0;
  wr_t exp_q[$];

  wb_port_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .clr(clr),
    .i_alu_en(i_alu_en), .i_alu_reg(i_alu_reg), .i_alu_data(i_alu_data),
    .i_ll_valid(i_ll_valid), .i_ll_reg(i_ll_reg), .i_ll_data(i_ll_data),
    .o_ll_ready(o_ll_ready), .o_stall(o_stall), .o_rf_we(o_rf_we),
    .o_rf_reg(o_rf_reg), .o_rf_data(o_rf_data), .o_stall_cnt(o_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every register file write must match the oldest expected write
  always @(negedge clk) begin
    if (o_rf_we) begin
      wr_t e;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL unexpected_write: got x%0d=0x%0h expected no write", o_rf_reg, o_rf_data);
      end else begin
        e = exp_q.pop_front();
        chk("rf_reg", 32'(o_rf_reg), 32'(e.r));
        chk("rf_data", o_rf_data, e.d);
      end
    end
  end

  // Drive one cycle of inputs, check the combinational grant, queue the expected write
  task automatic issue(input logic ae, input logic [`REG_IDX_W-1:0] ar, input logic [`WORD_W-1:0] ad,
                       input logic lv, input logic [`REG_IDX_W-1:0] lr, input logic [`WORD_W-1:0] ld,
                       input logic exp_ready);
    wr_t w;
    i_alu_en = ae; i_alu_reg = ar; i_alu_data = ad;
    i_ll_valid = lv; i_ll_reg = lr; i_ll_data = ld;
    #1;
    chk("ll_ready", 32'(o_ll_ready), 32'(exp_ready));
    if (ae && ar != 0) begin
      w.r = ar; w.d = ad; exp_q.push_back(w);
    end else if (exp_ready && lv && lr != 0) begin
      w.r = lr; w.d = ld; exp_q.push_back(w);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    issue(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  initial begin
    clr = 1'b0;
    i_alu_en = 0; i_alu_reg = 0; i_alu_data = 0;
    i_ll_valid = 0; i_ll_reg = 0; i_ll_data = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ll_ready", 32'(o_ll_ready), 0);
    clr = 1'b1;

    // 1. reset state, then single ALU write
    chk("rst_stall", 32'(o_stall), 0);
    chk("rst_rf_we", 32'(o_rf_we), 0);
    chk("rst_rf_reg", 32'(o_rf_reg), 0);
    chk("rst_rf_data", o_rf_data, 0);
    chk("rst_stall_cnt", 32'(o_stall_cnt), 0);
    issue(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("t1_rf_we", 32'(o_rf_we), 1);
    chk("t1_stall", 32'(o_stall), 0);

    // 2. LL write with ALU idle
    issue(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hAA, 1'b1);
    chk("t2_rf_we", 32'(o_rf_we), 1);
    idle();

    // 3. starvation: four blocked cycles force a stall
    issue(1'b1, 5'd1, 32'h11, 1'b1, 5'd9, 32'h99, 1'b0);
    issue(1'b1, 5'd2, 32'h22, 1'b1, 5'd9, 32'h99, 1'b0);
    issue(1'b1, 5'd3, 32'h33, 1'b1, 5'd9, 32'h99, 1'b0);
    chk("t3_no_stall_yet", 32'(o_stall), 0);
    issue(1'b1, 5'd4, 32'h44, 1'b1, 5'd9, 32'h99, 1'b0);
    chk("t3_stall_up", 32'(o_stall), 1);
    chk("t3_stall_cnt", 32'(o_stall_cnt), 1);
    issue(1'b1, 5'd5, 32'h55, 1'b1, 5'd9, 32'h99, 1'b0);
    chk("t3_stall_hold", 32'(o_stall), 1);
    issue(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 1'b1);
    chk("t3_stall_down", 32'(o_stall), 0);
    chk("t3_wait_cnt", 32'(dut.r_wait_cnt), 0);
    idle();

    // 4. x0 handling
    issue(1'b1, 5'd3, 32'h1, 1'b1, 5'd0, 32'h2, 1'b1);
    issue(1'b1, 5'd0, 32'h7, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("t4_x0_no_we", 32'(o_rf_we), 0);
    idle();

    // 5. async reset while in STALL with LL pending
    issue(1'b1, 5'd1, 32'h101, 1'b1, 5'd9, 32'h909, 1'b0);
    issue(1'b1, 5'd2, 32'h102, 1'b1, 5'd9, 32'h909, 1'b0);
    issue(1'b1, 5'd3, 32'h103, 1'b1, 5'd9, 32'h909, 1'b0);
    issue(1'b1, 5'd4, 32'h104, 1'b1, 5'd9, 32'h909, 1'b0);
    chk("t5_in_stall", 32'(o_stall), 1);
    chk("t5_cnt_before", 32'(o_stall_cnt), 2);
    i_alu_en = 1'b0; i_alu_reg = 0; i_alu_data = 0;
    @(negedge clk); #2;
    chk("t5_ready_pre", 32'(o_ll_ready), 1);
    clr = 1'b0;
    #1;
    chk("t5_rst_ready", 32'(o_ll_ready), 0);
    chk("t5_rst_stall", 32'(o_stall), 0);
    chk("t5_rst_we", 32'(o_rf_we), 0);
    chk("t5_rst_cnt", 32'(o_stall_cnt), 0);
    @(posedge clk); #1;
    clr = 1'b1;
    chk("t5_wait_cnt", 32'(dut.r_wait_cnt), 0);
    chk("t5_post_stall", 32'(o_stall), 0);
    issue(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h909, 1'b1);
    idle();

    // 6. stall counter saturation with CNT_W=4
    for (int n = 1; n <= 17; n++) begin
      for (int k = 1; k <= MAX_WAIT; k++) begin
        issue(1'b1, 5'(k), 32'(n * 16 + k), 1'b1, 5'd12, 32'(n), 1'b0);
      end
      chk("t6_stall", 32'(o_stall), 1);
      chk("t6_stall_cnt", 32'(o_stall_cnt), (n > 15) ? 32'd15 : 32'(n));
      issue(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'(n), 1'b1);
      chk("t6_release", 32'(o_stall), 0);
      idle();
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
